// File: rtl/spi_bus_pkg.sv
// spi_bus_pkg: shared FSM state type and default parameters for the shared SPI bus master
package spi_bus_pkg;
  localparam int N_CH_DEF    = 2;
  localparam int DATA_W_DEF  = 8;
  localparam int CLK_DIV_DEF = 2;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant, searching from the channel after the last accepted one
module rr_arbiter #(
  parameter int N_CH = 2,
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1
)(
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] req,
  input  logic            accept,
  output logic [N_CH-1:0] grant,
  output logic [IW-1:0]   gidx,
  output logic            any
);
  logic [IW-1:0] start_q, start_d;
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!any && req[(int'(start_q) + k) % N_CH]) begin
        any  = 1'b1;
        gidx = IW'((int'(start_q) + k) % N_CH);
      end
    end
    grant[gidx] = any;
    start_d = (gidx == IW'(N_CH - 1)) ? '0 : gidx + IW'(1);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) start_q <= '0;
    else if (accept) start_q <= start_d;
  end
endmodule

// File: rtl/spi_shared_bus.sv
// spi_shared_bus: mode-0 SPI master sharing sclk/mosi across N_CH round-robin arbitrated slaves
module spi_shared_bus
  import spi_bus_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
)(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_CH-1:0]        req_valid,
  output logic [N_CH-1:0]        req_ready,
  input  logic [N_CH*DATA_W-1:0] req_wdata,
  output logic [N_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   sclk,
  output logic                   mosi,
  output logic [N_CH-1:0]        ss_n,
  input  logic [N_CH-1:0]        miso,
  output logic                   busy
);
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(2 * DATA_W);
  state_t            state_q, state_d;
  logic [IW-1:0]     ch_q, ch_d, gidx;
  logic [DW-1:0]     div_q, div_d;
  logic [HW-1:0]     half_q, half_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic [N_CH-1:0]   ss_n_q, ss_n_d, rsp_q, rsp_d, grant;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, any, last_div, rise, fall;
  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req_valid),
    .accept (state_q == IDLE && any),
    .grant  (grant),
    .gidx   (gidx),
    .any    (any)
  );
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    div_d    = div_q;
    half_d   = half_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    last_div = div_q == DW'(CLK_DIV - 1);
    case (state_q)
      IDLE: if (any) begin
        state_d = SETUP;
        ch_d    = gidx;
        div_d   = '0;
        tx_d    = req_wdata[int'(gidx)*DATA_W +: DATA_W];
      end
      SETUP: begin
        div_d = last_div ? '0 : div_q + DW'(1);
        if (last_div) begin
          state_d = SHIFT;
          half_d  = '0;
        end
      end
      SHIFT: begin
        div_d = last_div ? '0 : div_q + DW'(1);
        if (last_div) begin
          if (half_q == HW'(2*DATA_W - 1)) state_d = DONE;
          else half_d = half_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // even half-periods are sclk high, so SHIFT opens on a rising edge
    sclk_d = state_d == SHIFT && !half_d[0];
    rise   = sclk_d && !sclk_q;
    fall   = !sclk_d && sclk_q && state_d == SHIFT && half_d != HW'(2*DATA_W - 1);
    rx_d   = rise ? DATA_W'({rx_q, miso[ch_q]}) : rx_d;
    tx_d   = fall ? DATA_W'({tx_q, 1'b0}) : tx_d;
    mosi_d = (state_d == SETUP || state_d == SHIFT) ? tx_d[DATA_W-1] : 1'b0;
    ss_n_d = '1;
    if (state_d == SETUP || state_d == SHIFT) ss_n_d[ch_d] = 1'b0;
    rsp_d = '0;
    if (state_d == DONE) begin
      rsp_d[ch_q] = 1'b1;
      rdata_d     = rx_q;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ch_q    <= '0;
      div_q   <= '0;
      half_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= '1;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      div_q   <= div_d;
      half_q  <= half_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      rsp_q   <= rsp_d;
    end
  end
  // grant is combinational, so mask it while reset holds the bus
  assign req_ready = (rstn && state_q == IDLE) ? grant : '0;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign ss_n      = ss_n_q;
  assign busy      = state_q != IDLE;
endmodule
